// File: rtl/apb_master_arbiter.sv
// Two-port APB master for the timer register block: round-robin grant between
// r0 (CPU) and r1 (DMA/debug), SETUP/ACCESS sequencing, pready timeout abort.
module apb_master_arbiter #(
  parameter int AW      = 32,
  parameter int DW      = 32,
  parameter int TIMEOUT = 16
) (
  input  logic          pclk,
  input  logic          preset,
  input  logic          r0_req,
  input  logic          r0_write,
  input  logic [AW-1:0] r0_addr,
  input  logic [DW-1:0] r0_wdata,
  output logic          r0_done,
  output logic [DW-1:0] r0_rdata,
  output logic          r0_err,
  input  logic          r1_req,
  input  logic          r1_write,
  input  logic [AW-1:0] r1_addr,
  input  logic [DW-1:0] r1_wdata,
  output logic          r1_done,
  output logic [DW-1:0] r1_rdata,
  output logic          r1_err,
  output logic          psel,
  output logic          penable,
  output logic          pwrite,
  output logic [AW-1:0] paddr,
  output logic [DW-1:0] pwdata,
  input  logic [DW-1:0] prdata,
  input  logic          pready,
  input  logic          pslverr
);

  // state    | meaning
  // S_IDLE   | bus idle, arbitrate and latch the winning request
  // S_SETUP  | psel=1, penable=0
  // S_ACCESS | psel=1, penable=1, wait for pready or timeout
  // S_RESP   | bus idle, done pulse to the granted port
  typedef enum logic [1:0] {S_IDLE, S_SETUP, S_ACCESS, S_RESP} state_t;

  localparam int CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CW-1:0] TO_MAX = CW'(TIMEOUT);

  state_t        state;
  logic          last;
  logic          gnt;
  logic          win;
  logic          timed_out;
  logic [CW-1:0] to_cnt;
  logic [DW-1:0] rsp_rdata;
  logic          rsp_err;

  always_comb begin
    win = 1'b0;
    if (r0_req && r1_req) win = ~last;
    else if (r1_req)      win = 1'b1;
  end

  // The counter reaches TIMEOUT after TIMEOUT low cycles; the abort is taken in
  // the following ACCESS cycle unless pready arrives there.
  always_comb timed_out = (TIMEOUT != 0) && (to_cnt == TO_MAX);

  always_comb begin
    rsp_err   = 1'b1;
    rsp_rdata = '0;
    if (pready) begin
      rsp_err   = pslverr;
      rsp_rdata = pwrite ? '0 : prdata;
    end
  end

  always_ff @(posedge pclk) begin
    if (preset) begin
      state    <= S_IDLE;
      last     <= 1'b1;
      gnt      <= 1'b0;
      to_cnt   <= '0;
      psel     <= 1'b0;
      penable  <= 1'b0;
      pwrite   <= 1'b0;
      paddr    <= '0;
      pwdata   <= '0;
      r0_done  <= 1'b0;
      r0_rdata <= '0;
      r0_err   <= 1'b0;
      r1_done  <= 1'b0;
      r1_rdata <= '0;
      r1_err   <= 1'b0;
    end else begin
      r0_done <= 1'b0;
      r1_done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (r0_req || r1_req) begin
            gnt    <= win;
            last   <= win;
            psel   <= 1'b1;
            pwrite <= win ? r1_write : r0_write;
            paddr  <= win ? r1_addr  : r0_addr;
            pwdata <= win ? r1_wdata : r0_wdata;
            state  <= S_SETUP;
          end
        end
        S_SETUP: begin
          penable <= 1'b1;
          to_cnt  <= '0;
          state   <= S_ACCESS;
        end
        S_ACCESS: begin
          if (pready || timed_out) begin
            if (gnt) begin
              r1_done  <= 1'b1;
              r1_rdata <= rsp_rdata;
              r1_err   <= rsp_err;
            end else begin
              r0_done  <= 1'b1;
              r0_rdata <= rsp_rdata;
              r0_err   <= rsp_err;
            end
            psel    <= 1'b0;
            penable <= 1'b0;
            pwrite  <= 1'b0;
            paddr   <= '0;
            pwdata  <= '0;
            state   <= S_RESP;
          end else if (TIMEOUT != 0) begin
            to_cnt <= to_cnt + CW'(1);
          end
        end
        S_RESP:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_apb_master_arbiter.sv
// Scoreboard bench for apb_master_arbiter: stimulus pushes expected APB setup
// phases and responses; a negedge monitor pops and compares them.
module tb_apb_master_arbiter;

  logic        pclk = 1'b0;
  logic        preset;
  logic        r0_req, r0_write, r1_req, r1_write;
  logic [31:0] r0_addr, r0_wdata, r1_addr, r1_wdata;
  logic        r0_done, r0_err, r1_done, r1_err;
  logic [31:0] r0_rdata, r1_rdata;
  logic        psel, penable, pwrite;
  logic [31:0] paddr, pwdata, prdata;
  logic        pready, pslverr;

  apb_master_arbiter #(.AW(32), .DW(32), .TIMEOUT(16)) dut (
    .pclk(pclk), .preset(preset),
    .r0_req(r0_req), .r0_write(r0_write), .r0_addr(r0_addr), .r0_wdata(r0_wdata),
    .r0_done(r0_done), .r0_rdata(r0_rdata), .r0_err(r0_err),
    .r1_req(r1_req), .r1_write(r1_write), .r1_addr(r1_addr), .r1_wdata(r1_wdata),
    .r1_done(r1_done), .r1_rdata(r1_rdata), .r1_err(r1_err),
    .psel(psel), .penable(penable), .pwrite(pwrite), .paddr(paddr), .pwdata(pwdata),
    .prdata(prdata), .pready(pready), .pslverr(pslverr)
  );

  always #5 pclk = ~pclk;

  int cyc = 0;
  always @(posedge pclk) cyc <= cyc + 1;

  int ncmp = 0;
  int nfail = 0;

  typedef struct { logic [31:0] addr; logic [31:0] wdata; logic wr; int cyc; } apb_exp_t;
  typedef struct { int port; logic [31:0] rdata; logic err; int cyc; } rsp_exp_t;
  apb_exp_t aq[$];
  rsp_exp_t rq[$];

  int          slv_wait = 0;
  logic [31:0] slv_rdata = 32'h0;
  logic        slv_err = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    ncmp++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s: got %h want %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic expect_xfer(input int port, input logic wr, input logic [31:0] addr,
                             input logic [31:0] wd, input int scyc,
                             input logic [31:0] rd, input logic er, input int dcyc);
    apb_exp_t a;
    rsp_exp_t r;
    a.addr = addr; a.wdata = wd; a.wr = wr; a.cyc = scyc;
    r.port = port; r.rdata = rd; r.err = er; r.cyc = dcyc;
    aq.push_back(a);
    rq.push_back(r);
  endtask

  task automatic align();
    @(posedge pclk);
    #1;
  endtask

  // Requester model: hold req until done, then drop it at the done edge.
  task automatic issue(input int port, input logic wr, input logic [31:0] addr,
                       input logic [31:0] wd);
    bit got;
    if (port == 0) begin
      r0_req = 1'b1; r0_write = wr; r0_addr = addr; r0_wdata = wd;
    end else begin
      r1_req = 1'b1; r1_write = wr; r1_addr = addr; r1_wdata = wd;
    end
    got = 1'b0;
    for (int k = 0; k < 200 && !got; k++) begin
      @(negedge pclk);
      if ((port == 0 ? r0_done : r1_done) === 1'b1) got = 1'b1;
    end
    if (!got) begin
      ncmp++;
      nfail++;
      $display("FAIL done_wait port %0d: got no done, want done within 200 cycles", port);
    end
    align();
    if (port == 0) begin
      r0_req = 1'b0; r0_write = 1'b0; r0_addr = '0; r0_wdata = '0;
    end else begin
      r1_req = 1'b0; r1_write = 1'b0; r1_addr = '0; r1_wdata = '0;
    end
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_apb_ctl"}, {29'h0, psel, penable, pwrite, paddr}, 64'h0);
    chk({tag, "_pwdata"}, {32'h0, pwdata}, 64'h0);
    chk({tag, "_done_err"}, {60'h0, r0_done, r1_done, r0_err, r1_err}, 64'h0);
    chk({tag, "_rdata"}, {r0_rdata, r1_rdata}, 64'h0);
  endtask

  // APB slave: pready rises in ACCESS cycle slv_wait+1.
  initial begin
    int acc;
    acc = 0;
    pready = 1'b0; prdata = '0; pslverr = 1'b0;
    forever begin
      @(posedge pclk);
      #1;
      if (psel === 1'b1 && penable === 1'b1) acc++;
      else acc = 0;
      pready  = (acc != 0) && (acc > slv_wait);
      prdata  = slv_rdata;
      pslverr = slv_err;
    end
  end

  apb_exp_t    ma;
  rsp_exp_t    mr;
  logic [31:0] cur_addr = '0;

  always @(negedge pclk) begin
    if (preset === 1'b0) begin
      if (psel === 1'b1 && penable === 1'b0) begin
        if (aq.size() == 0) begin
          chk("setup_unexpected", 64'h1, 64'h0);
        end else begin
          ma = aq.pop_front();
          chk("setup_cycle", 64'(cyc), 64'(ma.cyc));
          chk("setup_paddr", {32'h0, paddr}, {32'h0, ma.addr});
          chk("setup_pwdata", {32'h0, pwdata}, {32'h0, ma.wdata});
          chk("setup_pwrite", {63'h0, pwrite}, {63'h0, ma.wr});
          cur_addr = ma.addr;
        end
      end
      if (psel === 1'b1 && penable === 1'b1)
        chk("access_paddr_stable", {32'h0, paddr}, {32'h0, cur_addr});
      if (r0_done === 1'b1 || r1_done === 1'b1) begin
        chk("done_overlap", {63'h0, r0_done & r1_done}, 64'h0);
        chk("resp_bus_idle", {29'h0, psel, penable, pwrite, paddr}, 64'h0);
        if (rq.size() == 0) begin
          chk("done_unexpected", 64'h1, 64'h0);
        end else begin
          mr = rq.pop_front();
          chk("done_cycle", 64'(cyc), 64'(mr.cyc));
          chk("done_port", {63'h0, r1_done}, 64'(mr.port));
          chk("done_rdata", {32'h0, (r1_done ? r1_rdata : r0_rdata)}, {32'h0, mr.rdata});
          chk("done_err", {63'h0, (r1_done ? r1_err : r0_err)}, {63'h0, mr.err});
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish, want finish before 200000");
    nfail++;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
    $fatal(1);
  end

  initial begin
    int n;
    preset = 1'b1;
    r0_req = 1'b0; r0_write = 1'b0; r0_addr = '0; r0_wdata = '0;
    r1_req = 1'b0; r1_write = 1'b0; r1_addr = '0; r1_wdata = '0;
    repeat (3) @(posedge pclk);
    @(negedge pclk);
    check_all_zero("reset");
    align();
    preset = 1'b0;
    align();

    // single zero-wait write on r0
    n = cyc; slv_wait = 0;
    expect_xfer(0, 1'b1, 32'h04, 32'hA5, n + 1, 32'h0, 1'b0, n + 3);
    issue(0, 1'b1, 32'h04, 32'hA5);

    // r1 read with two wait states
    n = cyc; slv_wait = 2; slv_rdata = 32'h1234;
    expect_xfer(1, 1'b0, 32'h08, 32'h0, n + 1, 32'h1234, 1'b0, n + 5);
    issue(1, 1'b0, 32'h08, 32'h0);

    // both ports requesting continuously: strict alternation
    n = cyc; slv_wait = 0;
    expect_xfer(0, 1'b1, 32'h10, 32'h11, n + 1,  32'h0, 1'b0, n + 3);
    expect_xfer(1, 1'b1, 32'h20, 32'h22, n + 5,  32'h0, 1'b0, n + 7);
    expect_xfer(0, 1'b1, 32'h14, 32'h33, n + 9,  32'h0, 1'b0, n + 11);
    expect_xfer(1, 1'b1, 32'h24, 32'h44, n + 13, 32'h0, 1'b0, n + 15);
    fork
      begin issue(0, 1'b1, 32'h10, 32'h11); issue(0, 1'b1, 32'h14, 32'h33); end
      begin issue(1, 1'b1, 32'h20, 32'h22); issue(1, 1'b1, 32'h24, 32'h44); end
    join
    align();

    // slave error, then a clean transfer
    n = cyc; slv_err = 1'b1; slv_rdata = 32'hDEAD;
    expect_xfer(0, 1'b0, 32'hFF, 32'h0, n + 1, 32'hDEAD, 1'b1, n + 3);
    issue(0, 1'b0, 32'hFF, 32'h0);
    n = cyc; slv_err = 1'b0; slv_rdata = 32'h55;
    expect_xfer(1, 1'b0, 32'h0C, 32'h0, n + 1, 32'h55, 1'b0, n + 3);
    issue(1, 1'b0, 32'h0C, 32'h0);
    chk("hold_r0_rdata", {32'h0, r0_rdata}, 64'hDEAD);
    chk("hold_r0_err", {63'h0, r0_err}, 64'h1);

    // pready stuck low: timeout abort
    n = cyc; slv_wait = 1000;
    expect_xfer(1, 1'b0, 32'h30, 32'h0, n + 1, 32'h0, 1'b1, n + 19);
    issue(1, 1'b0, 32'h30, 32'h0);
    chk("timeout_bus_idle", {29'h0, psel, penable, pwrite, paddr}, 64'h0);

    // pready in the 16th ACCESS cycle completes normally
    n = cyc; slv_wait = 15; slv_rdata = 32'h77;
    expect_xfer(0, 1'b0, 32'h34, 32'h0, n + 1, 32'h77, 1'b0, n + 18);
    issue(0, 1'b0, 32'h34, 32'h0);

    // write returns rdata 0 even with prdata nonzero
    n = cyc; slv_wait = 0; slv_rdata = 32'h99;
    expect_xfer(0, 1'b1, 32'h40, 32'h1, n + 1, 32'h0, 1'b0, n + 3);
    issue(0, 1'b1, 32'h40, 32'h1);

    // reset during ACCESS: transfer lost, no done
    n = cyc; slv_wait = 1000;
    begin
      apb_exp_t a;
      a.addr = 32'h50; a.wdata = 32'h0; a.wr = 1'b0; a.cyc = n + 1;
      aq.push_back(a);
    end
    r0_req = 1'b1; r0_write = 1'b0; r0_addr = 32'h50; r0_wdata = '0;
    repeat (3) align();
    preset = 1'b1;
    r0_req = 1'b0; r0_addr = '0;
    align();
    preset = 1'b0;
    @(negedge pclk);
    check_all_zero("midreset");
    align();

    // simultaneous pair after reset: r0 wins first
    n = cyc; slv_wait = 0; slv_rdata = 32'h99;
    expect_xfer(0, 1'b1, 32'h60, 32'h6, n + 1, 32'h0,  1'b0, n + 3);
    expect_xfer(1, 1'b0, 32'h64, 32'h0, n + 5, 32'h99, 1'b0, n + 7);
    fork
      issue(1, 1'b0, 32'h64, 32'h0);
      issue(0, 1'b1, 32'h60, 32'h6);
    join

    repeat (4) align();
    chk("apb_queue_empty", 64'(aq.size()), 64'h0);
    chk("rsp_queue_empty", 64'(rq.size()), 64'h0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
    $finish;
  end

endmodule
